// File: rtl/switch_logic_unit_pkg.sv
// switch_logic_unit_pkg: operator codes and per-bit operator evaluation
package switch_logic_unit_pkg;
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    OP_AND      = 3'd0,
    OP_OR       = 3'd1,
    OP_XOR      = 3'd2,
    OP_IMPLIES  = 3'd3,
    OP_NAND     = 3'd4,
    OP_NOR      = 3'd5,
    OP_XNOR     = 3'd6,
    OP_CONVERSE = 3'd7
  } op_e;
  function automatic logic apply_op(input op_e op, input logic a, input logic b);
    apply_op = a & b;
    case (op)
      OP_AND:      apply_op = a & b;
      OP_OR:       apply_op = a | b;
      OP_XOR:      apply_op = a ^ b;
      OP_IMPLIES:  apply_op = ~a | b;
      OP_NAND:     apply_op = ~(a & b);
      OP_NOR:      apply_op = ~(a | b);
      OP_XNOR:     apply_op = ~(a ^ b);
      OP_CONVERSE: apply_op = a | ~b;
      default:     apply_op = a & b;
    endcase
  endfunction
endpackage

// File: rtl/switch_logic_unit_debounce.sv
// switch_debounce: 2-FF synchroniser plus stable-count filter for one raw input
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1_q, s2_q, deb_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  assign clean = deb_q;
endmodule

// File: rtl/switch_logic_unit.sv
// switch_logic_unit: debounced switches/button drive a mode-selected bitwise operator onto registered LEDs
module switch_logic_unit
  import switch_logic_unit_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*WIDTH-1:0]  switch,
  input  logic                btn_mode,
  output logic [WIDTH-1:0]    led,
  output logic [MODE_W-1:0]   mode,
  output logic                led_update
);
  logic [2*WIDTH:0] raw, clean;
  logic [WIDTH-1:0] a, b, led_q, led_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic deb_btn, btn_q, upd_q;
  assign raw = {btn_mode, switch};
  for (genvar i = 0; i <= 2 * WIDTH; i++) begin : g_deb
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .clean(clean[i])
    );
  end
  assign a       = clean[WIDTH-1:0];
  assign b       = clean[2*WIDTH-1:WIDTH];
  assign deb_btn = clean[2*WIDTH];
  always_comb begin
    mode_d = (deb_btn && !btn_q) ? mode_q + MODE_W'(1) : mode_q;
    led_d  = '0;
    for (int k = 0; k < WIDTH; k++) led_d[k] = apply_op(op_e'(mode_q), a[k], b[k]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      btn_q  <= 1'b0;
      led_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      btn_q  <= deb_btn;
      led_q  <= led_d;
      upd_q  <= (led_d != led_q);
    end
  end
  assign led        = led_q;
  assign mode       = mode_q;
  assign led_update = upd_q;
endmodule

// File: tb/tb_switch_logic_unit.sv
// tb_switch_logic_unit: directed stimulus with a led_update-driven scoreboard monitor
module tb_switch_logic_unit;
  typedef struct {
    logic [3:0] led;
    logic [2:0] mode;
    int         cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] switch;
  logic btn_mode;
  logic [3:0] led;
  logic [2:0] mode;
  logic led_update;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [3:0] cur_led;
  logic [2:0] cur_mode;
  switch_logic_unit #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .switch    (switch),
    .btn_mode  (btn_mode),
    .led       (led),
    .mode      (mode),
    .led_update(led_update)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && led_update) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: got led=%h mode=%0d at cyc %0d, required no pulse", led, mode, cyc);
      end else begin
        mon_e = q.pop_front();
        if (led == mon_e.led && mode == mon_e.mode && cyc == mon_e.cyc) passed++;
        else $display("FAIL pulse: got led=%h mode=%0d cyc=%0d, required led=%h mode=%0d cyc=%0d",
                      led, mode, cyc, mon_e.led, mon_e.mode, mon_e.cyc);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask
  task automatic expect_led(input logic [3:0] nled, input logic [2:0] nmode, input int at);
    if (nled != cur_led) q.push_back('{nled, nmode, at});
    cur_led  = nled;
    cur_mode = nmode;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() == 0) passed++;
    else begin
      $display("FAIL drain: got %0d outstanding pulses, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic press(input logic [3:0] nled, input logic [2:0] nmode);
    @(negedge clk);
    btn_mode = 1'b1;
    expect_led(nled, nmode, cyc + 8);
    repeat (6) @(negedge clk);
    btn_mode = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic set_sw(input logic [7:0] v, input logic [3:0] nled);
    @(negedge clk);
    switch = v;
    expect_led(nled, cur_mode, cyc + 7);
    repeat (10) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    switch = 8'hFF;
    btn_mode = 1'b0;
    cur_led = 4'h0;
    cur_mode = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_led", {4'h0, led}, 8'h00);
    chk("rst_mode", {5'h0, mode}, 8'h00);
    chk("rst_upd", {7'h0, led_update}, 8'h00);
    rst = 1'b0;
    expect_led(4'hF, 3'd0, cyc + 7);
    drain();
    press(4'hF, 3'd1);
    press(4'h0, 3'd2);
    press(4'hF, 3'd3);
    chk("mode_imp", {5'h0, mode}, 8'h03);
    set_sw(8'h53, 4'hD);
    drain();
    chk("led_imp", {4'h0, led}, 8'h0D);
    press(4'hE, 3'd4);
    press(4'h8, 3'd5);
    press(4'h9, 3'd6);
    press(4'hB, 3'd7);
    press(4'h1, 3'd0);
    chk("mode_back0", {5'h0, mode}, 8'h00);
    set_sw(8'hF0, 4'h0);
    drain();
    @(negedge clk);
    switch[0] = 1'b1;
    repeat (3) @(negedge clk);
    switch[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_led", {4'h0, led}, 8'h00);
    @(negedge clk);
    switch[0] = 1'b1;
    expect_led(4'h1, 3'd0, cyc + 7);
    repeat (4) @(negedge clk);
    switch[0] = 1'b0;
    expect_led(4'h0, 3'd0, cyc + 7);
    drain();
    press(4'hF, 3'd1);
    press(4'hF, 3'd2);
    press(4'hF, 3'd3);
    press(4'hF, 3'd4);
    press(4'h0, 3'd5);
    press(4'h0, 3'd6);
    press(4'h0, 3'd7);
    press(4'h0, 3'd0);
    chk("wrap_mode", {5'h0, mode}, 8'h00);
    drain();
    @(negedge clk);
    btn_mode = 1'b1;
    expect_led(4'hF, 3'd1, cyc + 8);
    repeat (50) @(negedge clk);
    chk("hold_mode", {5'h0, mode}, 8'h01);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_release_mode", {5'h0, mode}, 8'h01);
    drain();
    @(negedge clk);
    switch = 8'h33;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_led", {4'h0, led}, 8'h00);
    chk("midrst_mode", {5'h0, mode}, 8'h00);
    chk("midrst_upd", {7'h0, led_update}, 8'h00);
    cur_led = 4'h0;
    cur_mode = 3'd0;
    rst = 1'b0;
    expect_led(4'h3, 3'd0, cyc + 7);
    repeat (12) @(negedge clk);
    drain();
    @(negedge clk);
    switch = 8'hF0;
    btn_mode = 1'b1;
    expect_led(4'h0, 3'd1, cyc + 7);
    expect_led(4'hF, 3'd1, cyc + 8);
    repeat (6) @(negedge clk);
    btn_mode = 1'b0;
    repeat (8) @(negedge clk);
    drain();
    chk("sim_mode", {5'h0, mode}, 8'h01);
    chk("sim_led", {4'h0, led}, 8'h0F);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/switch_logic_unit.md
# switch_logic_unit

Parametrised, clocked successor to the board-level switch/LED logic exercises. It takes two WIDTH-bit operand fields from the slide switches and debounces every switch and a mode push-button. It applies a button-selected bitwise Boolean operator, including implication, and drives the registered result to the LEDs. It sits directly between the board switch/button pins and the LED pins in the lab top level.

## Interface
Parameters:
- WIDTH, 4: bits per operand; result width.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required before a debounced input changes; minimum 2.

Ports:
- clk  in  1  board clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- switch  in  2*WIDTH  raw switches; A = switch[WIDTH-1:0], B = switch[2*WIDTH-1:WIDTH].
- btn_mode  in  1  raw push-button; each debounced press advances the operator.
- led  out  WIDTH  registered result, bit i = op(A[i], B[i]).
- mode  out  3  current operator code.
- led_update  out  1  one-cycle pulse when led changes value.

## Operation
- Each of the 2*WIDTH switch bits and btn_mode passes through its own debouncer:
  - 2-FF synchroniser (s1, s2), then a counter cnt of width clog2(DEBOUNCE_CYCLES).
  - If s2 == deb: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: deb <= s2 and cnt <= 0. Otherwise cnt <= cnt+1.
  - Pulses shorter than DEBOUNCE_CYCLES cycles never reach deb.
- Operator codes:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 IMPLIES (A→B = ~A|B)
  - 4 NAND
  - 5 NOR
  - 6 XNOR
  - 7 CONVERSE (B→A = A|~B)
- Mode advance:
  - A rising edge of the debounced button (deb_btn=1, previous deb_btn=0) sets mode <= mode+1.
  - Mode wraps from 7 to 0.
  - Holding the button produces exactly one advance.
- Output path:
  - Every cycle: led <= op(mode, debA, debB).
  - led_update <= (new led != current led).
- Reset values:
  - All s1/s2/deb/cnt = 0, previous deb_btn = 0.
  - mode = 0, led = 0, led_update = 0.
- Reset asserted mid-debounce or mid-press discards all progress on the next edge.
- After release, inputs held high since before reset need the full debounce latency to appear.
- Boundary conditions:
  - A switch that toggles back to match deb before the count completes clears cnt, so no change occurs.
  - A switch change and a mode advance on the same edge are both applied. The next led computation uses both the new operand and the new mode.

## Timing
- Switch latency: a level change sampled at edge 0 gives s2 at edge 1 and deb at edge D+1, where D = DEBOUNCE_CYCLES. led and led_update update at edge D+2.
- Button latency: a press sampled at edge 0 gives deb_btn at edge D+1 and mode at edge D+2. led and led_update reflect the new mode at edge D+3.
- led_update is high for exactly one cycle per led change. It never stays high for two consecutive cycles unless led changes on both edges.
- No combinational path from any input to any output.

## Structure
- Shared package: the 3-bit operator code constants (OP_AND … OP_CONVERSE) and the mode width.
- Sub-module switch_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, clean), instantiated 2*WIDTH+1 times in a generate loop.
- The top holds the mode counter, the edge detect, the operator mux and the output registers.

## Test plan
All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=4.
- Reset: switch=8'hFF held through reset → led=0, mode=0, led_update=0 while rst is high. After release, led=4'hF (AND) exactly 6 edges after the first post-reset sample, with a single led_update pulse.
- Implication: press btn_mode 3 times (each press held ≥6 cycles, released ≥6 cycles) → mode=3. Then A=4'b0011, B=4'b0101 → led=4'b1101.
- Glitch reject: toggle switch[0] high for 3 cycles, then low, with mode=0 and B=4'hF → led and led_update unchanged. A 4-cycle pulse then propagates.
- Wrap: 8 presses from mode=0 → mode=0. Holding btn_mode for 50 cycles → exactly one advance.
- Mid-operation reset: assert rst during the 3rd stable cycle of a switch change → all outputs return to reset values on the next edge. The change completes only after a fresh D+2 edges once rst is released.
- Simultaneous: A change and a btn press timed so the mode advance lands on the edge where led first reflects the new A → led shows the new-mode result one edge later, with a led_update pulse on each change.
